motor_tach_emulator: RTL and testbench
======================================

Name: motor_tach_emulator

Overview:
- Plant model for the PID motor loop. It consumes the controller's motor drive outputs (EN as PWM, DIR) and produces the quadrature tachometer signals SA/SB that the controller's tach input decodes.
- It replaces the physical motor/encoder for closed-loop bring-up, both in simulation and on the board via the JA header loopback.
- Its model is PWM duty measurement, then a slew-limited speed, then a phase accumulator, then quadrature edges.

Parameters:
- WIN_BITS, 12, duty window is 2^WIN_BITS clk cycles; the duty/speed range is 0..2^WIN_BITS.
- RAMP_STEP, 64, maximum speed change per window (emulated inertia); must be ≥1.
- ACC_BITS, 20, phase accumulator width; must be > WIN_BITS.
- PPR, 48, quadrature steps per revolution; used only with MOTOR_EMU_INDEX_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en_pwm  in  1  motor enable/PWM from controller, synchronous to clk
- dir  in  1  commanded direction: 1 = forward, 0 = reverse
- sa  out  1  tach channel A
- sb  out  1  tach channel B
- speed  out  WIN_BITS+1  current emulated speed, in duty counts
- dir_act  out  1  direction actually being emulated
- window_done  out  1  one-cycle strobe at each window end

Behaviour:
- Reset (async, active-high):
  - win_cnt, high_cnt, acc and speed clear to 0.
  - sa=0, sb=0, dir_act=1, window_done=0.
  - Reset mid-run forces these values immediately, with no partial-window carry-over.
- Duty measurement:
  - win_cnt free-runs 0..2^WIN_BITS−1 and wraps.
  - high_cnt (WIN_BITS+1 bits) increments each cycle en_pwm=1.
  - The last cycle of a window (win_cnt = max) is included in that window. duty = high_cnt including that cycle, so 100% duty gives exactly 2^WIN_BITS.
  - high_cnt restarts at 0 (or 1 if en_pwm=1) on the first cycle of the next window.
- Window end (clock edge leaving win_cnt = max); window_done=1 for the following cycle.
  - target = 0 if dir ≠ dir_act, else duty.
  - If dir ≠ dir_act and speed = 0 (pre-update value), dir_act ← dir, and target = duty for this same update.
  - Ramp: if |target − speed| ≤ RAMP_STEP then speed ← target; otherwise speed ← speed ± RAMP_STEP toward target.
  - Reversal therefore always decelerates to 0, spends one window at 0, then flips and accelerates.
- Phase accumulator:
  - Every cycle: {carry, acc} ← acc + speed (zero-extended).
  - When speed = 0 the accumulator holds and no edges occur.
  - A carry advances the quadrature state on that same clock edge, so at most one step per cycle.
- Quadrature, (sa,sb):
  - Forward (dir_act=1): 00→10→11→01→00, so SA leads SB.
  - Reverse: 00→01→11→10→00.
  - Exactly one output toggles per step; outputs are registered and glitch-free.
- A speed change takes effect on the accumulator starting the cycle after the window-end edge.
- A dir change with speed = 0 flips at the next window end, not immediately.

Optional Feature:
- Macro: MOTOR_EMU_INDEX_EN.
- When defined:
  - Adds output port tach_index (1 bit).
  - A step counter 0..PPR−1 increments on forward steps and decrements on reverse steps, wrapping at both ends.
  - tach_index=1 for exactly one cycle when the counter transitions to 0.
  - Reset clears the counter and tach_index.
- When undefined: no port and no counter logic.

Test Plan:
- Reset behaviour: run with en_pwm=1 to nonzero speed, assert reset for 3 cycles mid-window → sa=sb=0, speed=0, dir_act=1 within the same cycle. After release, the first window_done occurs exactly 2^WIN_BITS cycles later.
- Full duty (WIN_BITS=4, RAMP_STEP=16, ACC_BITS=8), en_pwm=1, dir=1 → first window_done with speed=16. Then (sa,sb) steps 10,11,01,00 every 16 cycles.
- Half duty (WIN_BITS=4, RAMP_STEP=4), en_pwm 8 high/8 low → speed 4, then 8, then holds 8; an edge every 32 cycles with ACC_BITS=8.
- Reversal, from the full-duty state (speed=16), set dir=0:
  - Next window: speed=0, dir_act=1, no further edges.
  - Following window: dir_act=0, speed=16.
  - Sequence then runs 00→01→11→10.
- Idle: en_pwm=0 for 10 windows from reset → speed=0, sa=sb=0, no toggles, window_done every 16 cycles.
- Index (MOTOR_EMU_INDEX_EN, PPR=4), full-duty forward → tach_index one-cycle pulse every 4 steps (64 cycles). After reversal, pulses continue every 4 reverse steps.

Source files
------------

// File: rtl/motor_tach_emulator.sv
// Motor/encoder plant model: PWM duty -> slew-limited speed -> phase accumulator -> quadrature tach.
// Optional index output enabled by defining MOTOR_EMU_INDEX_EN.
module motor_tach_emulator #(
  parameter int WIN_BITS  = 12,
  parameter int RAMP_STEP = 64,
  parameter int ACC_BITS  = 20,
  parameter int PPR       = 48
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_pwm,
  input  logic                dir,
  output logic                sa,
  output logic                sb,
  output logic [WIN_BITS:0]   speed,
  output logic                dir_act,
  output logic                window_done
`ifdef MOTOR_EMU_INDEX_EN
  ,
  output logic                tach_index
`endif
);

  if (RAMP_STEP < 1 || ACC_BITS <= WIN_BITS || PPR < 1) begin : g_bad_param
    $error("motor_tach_emulator: illegal parameter combination");
  end

  localparam logic [WIN_BITS:0] RAMP = (WIN_BITS+1)'(RAMP_STEP);

  logic [WIN_BITS-1:0] win_cnt;
  logic [WIN_BITS:0]   high_cnt;
  logic [WIN_BITS:0]   duty;
  logic [WIN_BITS:0]   target;
  logic [WIN_BITS:0]   speed_nxt;
  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS:0]   acc_sum;
  logic                win_end;
  logic                dir_flip;
  logic                step;
  logic                tog_sa;

  assign win_end  = &win_cnt;
  // duty includes the current cycle so the last cycle of a window is counted
  assign duty     = high_cnt + {{WIN_BITS{1'b0}}, en_pwm};
  assign dir_flip = (dir != dir_act) && (speed == '0);
  assign acc_sum  = {1'b0, acc} + {{(ACC_BITS-WIN_BITS){1'b0}}, speed};
  assign step     = acc_sum[ACC_BITS];
  // forward toggles SA when the channels agree, reverse toggles SB
  assign tog_sa   = ((sa == sb) == dir_act);

  always_comb begin
    target = duty;
    if ((dir != dir_act) && !dir_flip) target = '0;
  end

  always_comb begin
    speed_nxt = target;
    if (target > speed) begin
      if ((target - speed) > RAMP) speed_nxt = speed + RAMP;
    end else begin
      if ((speed - target) > RAMP) speed_nxt = speed - RAMP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt     <= '0;
      high_cnt    <= '0;
      acc         <= '0;
      speed       <= '0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      dir_act     <= 1'b1;
      window_done <= 1'b0;
    end else begin
      win_cnt     <= win_cnt + 1'b1;
      high_cnt    <= win_end ? '0 : duty;
      window_done <= win_end;
      acc         <= acc_sum[ACC_BITS-1:0];
      if (win_end) begin
        speed <= speed_nxt;
        if (dir_flip) dir_act <= dir;
      end
      if (step) begin
        sa <= sa ^ tog_sa;
        sb <= sb ^ ~tog_sa;
      end
    end
  end

`ifdef MOTOR_EMU_INDEX_EN
  localparam int IDX_W = (PPR > 1) ? $clog2(PPR) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PPR - 1);

  logic [IDX_W-1:0] idx_cnt;
  logic [IDX_W-1:0] idx_nxt;

  always_comb begin
    idx_nxt = idx_cnt;
    if (dir_act) idx_nxt = (idx_cnt == IDX_MAX) ? '0 : idx_cnt + 1'b1;
    else         idx_nxt = (idx_cnt == '0) ? IDX_MAX : idx_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_cnt    <= '0;
      tach_index <= 1'b0;
    end else begin
      tach_index <= 1'b0;
      if (step) begin
        idx_cnt    <= idx_nxt;
        tach_index <= (idx_nxt == '0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_motor_tach_emulator.sv
// Directed self-checking bench for motor_tach_emulator (WIN_BITS=4, ACC_BITS=8).
// dut0: RAMP_STEP=16 (idle, full duty, reversal, reset); dut1: RAMP_STEP=4 (half duty).
module tb_motor_tach_emulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       en0, dir0, en1, dir1;
  logic       sa0, sb0, dir_act0, wd0;
  logic       sa1, sb1, dir_act1, wd1;
  logic [4:0] speed0, speed1;
  int         total = 0;
  int         bad   = 0;
  int         tog0  = 0;
  int         tog1  = 0;
  int         t0, t1, ts;

  always #5 clk = ~clk;

`ifdef MOTOR_EMU_INDEX_EN
  logic idx_pulse0, idx_pulse1;
  int   idx_hits0 = 0;
  always @(negedge clk) if (idx_pulse0 === 1'b1) idx_hits0++;
`endif

  motor_tach_emulator #(.WIN_BITS(4), .RAMP_STEP(16), .ACC_BITS(8), .PPR(4)) dut0 (
    .clk(clk), .reset(reset), .en_pwm(en0), .dir(dir0),
    .sa(sa0), .sb(sb0), .speed(speed0), .dir_act(dir_act0), .window_done(wd0)
`ifdef MOTOR_EMU_INDEX_EN
    , .tach_index(idx_pulse0)
`endif
  );

  motor_tach_emulator #(.WIN_BITS(4), .RAMP_STEP(4), .ACC_BITS(8), .PPR(4)) dut1 (
    .clk(clk), .reset(reset), .en_pwm(en1), .dir(dir1),
    .sa(sa1), .sb(sb1), .speed(speed1), .dir_act(dir_act1), .window_done(wd1)
`ifdef MOTOR_EMU_INDEX_EN
    , .tach_index(idx_pulse1)
`endif
  );

  always @(sa0 or sb0) tog0++;
  always @(sa1 or sb1) tog1++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // dut1 {sa,sb} after window w: speed 4 then 8, carries at cycles 56, 88, 120, 152
  function automatic logic [1:0] half_q(input int w);
    case (w)
      4, 5:    return 2'b10;
      6, 7:    return 2'b11;
      8, 9:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] fwd_q(input int i);
    case (i)
      0:       return 2'b10;
      1:       return 2'b11;
      2:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_q(input int i);
    case (i)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  initial begin
    reset = 1'b1; en0 = 1'b0; dir0 = 1'b1; en1 = 1'b0; dir1 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sa", sa0, 0);
    check("rst_sb", sb0, 0);
    check("rst_speed", speed0, 0);
    check("rst_dir_act", dir_act0, 1);
    check("rst_wd", wd0, 0);
    reset = 1'b0;
    t0 = tog0;
    t1 = tog1;

    // dut0 idle, dut1 at 8/16 duty
    for (int w = 1; w <= 10; w++) begin
      en1 = 1'b1;
      repeat (8) @(negedge clk);
      en1 = 1'b0;
      repeat (7) @(negedge clk);
      check("idle_wd_low", wd0, 0);
      @(negedge clk);
      check("idle_wd_high", wd0, 1);
      check("half_speed", speed1, (w == 1) ? 16'd4 : 16'd8);
      check("half_quad", {sa1, sb1}, half_q(w));
    end
    check("idle_speed", speed0, 0);
    check("idle_quad", {sa0, sb0}, 0);
    check("idle_toggles", tog0 - t0, 0);
    check("half_toggles", tog1 - t1, 4);

    // full duty forward
    en0 = 1'b1;
    repeat (16) @(negedge clk);
    check("full_speed", speed0, 16);
    check("full_wd", wd0, 1);
    check("full_quad0", {sa0, sb0}, 0);
    for (int i = 0; i < 4; i++) begin
      repeat (16) @(negedge clk);
      check("full_quad", {sa0, sb0}, fwd_q(i));
    end

    // reversal: carry at the decel window end still steps forward once
    dir0 = 1'b0;
    repeat (16) @(negedge clk);
    check("rev_speed0", speed0, 0);
    check("rev_dir_hold", dir_act0, 1);
    check("rev_quad_a", {sa0, sb0}, 2'b10);
    ts = tog0;
    repeat (16) @(negedge clk);
    check("rev_speed16", speed0, 16);
    check("rev_dir_flip", dir_act0, 0);
    check("rev_quad_b", {sa0, sb0}, 2'b10);
    check("rev_zero_toggles", tog0 - ts, 0);
    for (int i = 0; i < 4; i++) begin
      repeat (16) @(negedge clk);
      check("rev_quad", {sa0, sb0}, rev_q(i));
    end
`ifdef MOTOR_EMU_INDEX_EN
    check("index_pulses", idx_hits0, 2);
`endif

    // mid-window reset
    repeat (5) @(negedge clk);
    check("pre_rst_speed", speed0, 16);
    reset = 1'b1;
    #1;
    check("mid_rst_sa", sa0, 0);
    check("mid_rst_sb", sb0, 0);
    check("mid_rst_speed", speed0, 0);
    check("mid_rst_dir_act", dir_act0, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_wd_low", wd0, 0);
    check("post_rst_dir_wait", dir_act0, 1);
    @(negedge clk);
    check("post_rst_wd_high", wd0, 1);
    check("post_rst_dir_flip", dir_act0, 0);
    check("post_rst_speed", speed0, 16);
    @(negedge clk);
    check("post_rst_wd_pulse", wd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
